// File: rtl/mmd_pkg.sv
// Shared definitions for the multi-modulus divider: ratio width, legal
// ratio bounds and the FSM state encoding.
package mmd_pkg;

  localparam int RATIO_W       = 4;
  localparam int MIN_RATIO_DEF = 5;
  localparam int MAX_RATIO_DEF = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mmd_ratio_clamp.sv
// Forces a raw DSM ratio into [MIN_RATIO, MAX_RATIO] and flags when it had to.
module mmd_ratio_clamp
  import mmd_pkg::*;
#(
  parameter int MIN_RATIO = MIN_RATIO_DEF,
  parameter int MAX_RATIO = MAX_RATIO_DEF
) (
  input  logic [RATIO_W-1:0] ratio_in,
  output logic [RATIO_W-1:0] ratio_out,
  output logic               out_of_range
);

  // Saturate to the nearest legal bound; legal values pass straight through.
  always_comb begin
    ratio_out    = ratio_in;
    out_of_range = 1'b0;
    if (ratio_in < RATIO_W'(MIN_RATIO)) begin
      ratio_out    = RATIO_W'(MIN_RATIO);
      out_of_range = 1'b1;
    end else if (ratio_in > RATIO_W'(MAX_RATIO)) begin
      ratio_out    = RATIO_W'(MAX_RATIO);
      out_of_range = 1'b1;
    end
  end

endmodule

// File: rtl/mmd_divider.sv
// Multi-modulus clock divider. Each divided period lasts exactly N clk
// cycles; a new N is taken from the DSM in the last cycle of every period,
// so periods follow each other with no gap while enable stays high.
module mmd_divider
  import mmd_pkg::*;
#(
  parameter int MIN_RATIO = MIN_RATIO_DEF,
  parameter int MAX_RATIO = MAX_RATIO_DEF,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [RATIO_W-1:0] ratio_in,
  output logic               ratio_ack,
  output logic               div_pulse,
  output logic               div_clk,
  output logic [RATIO_W-1:0] cur_ratio,
  output logic               ratio_err,
  output logic [CNT_W-1:0]   period_cnt
);

  state_t             state_reg, state_next;
  logic [RATIO_W-1:0] cnt_reg, cnt_next;
  logic [RATIO_W-1:0] ratio_reg, ratio_next;
  logic               err_reg;
  logic               div_clk_reg, div_clk_next;
  logic               div_pulse_reg, div_pulse_next;
  logic [CNT_W-1:0]   period_cnt_reg;

  logic [RATIO_W-1:0] clamped_ratio;
  logic               clamp_hit;
  logic               last_cycle;
  logic               load;

  mmd_ratio_clamp #(
    .MIN_RATIO (MIN_RATIO),
    .MAX_RATIO (MAX_RATIO)
  ) u_clamp (
    .ratio_in     (ratio_in),
    .ratio_out    (clamped_ratio),
    .out_of_range (clamp_hit)
  );

  // Next-state decode; div_clk/div_pulse are precomputed for the next cycle
  // so they can leave the block straight from flops.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ratio_next = ratio_reg;
    last_cycle = (state_reg == RUN) && (cnt_reg == '0);
    load       = enable && ((state_reg == IDLE) || last_cycle);
    if (load) begin
      state_next = RUN;
      ratio_next = clamped_ratio;
      cnt_next   = clamped_ratio - RATIO_W'(1);
    end else if (last_cycle) begin
      // enable dropped at some point in this period: finish it, then stop
      state_next = IDLE;
    end else if (state_reg == RUN) begin
      cnt_next = cnt_reg - RATIO_W'(1);
    end
    // high while k < ceil(N/2), i.e. while cnt >= floor(N/2)
    div_clk_next   = (state_next == RUN) && (cnt_next >= (ratio_next >> 1));
    div_pulse_next = (state_next == RUN) && (cnt_next == '0);
  end

  // State, counters and registered outputs; reset aborts any period silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      ratio_reg      <= '0;
      err_reg        <= 1'b0;
      div_clk_reg    <= 1'b0;
      div_pulse_reg  <= 1'b0;
      period_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ratio_reg     <= ratio_next;
      div_clk_reg   <= div_clk_next;
      div_pulse_reg <= div_pulse_next;
      if (load && clamp_hit) begin
        err_reg <= 1'b1;
      end
      if (last_cycle) begin
        period_cnt_reg <= period_cnt_reg + CNT_W'(1);
      end
    end
  end

  // The ack is a same-cycle handshake, so it stays combinational; it is
  // gated by rst_n so that nothing is acknowledged while reset is held.
  assign ratio_ack  = load && rst_n;
  assign div_pulse  = div_pulse_reg;
  assign div_clk    = div_clk_reg;
  assign cur_ratio  = ratio_reg;
  assign ratio_err  = err_reg;
  assign period_cnt = period_cnt_reg;

endmodule

// File: tb/tb_mmd_divider.sv
// Bench for mmd_divider: a period-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mmd_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  ratio_in = 4'd0;
  logic        ratio_ack, div_pulse, div_clk, ratio_err;
  logic [3:0]  cur_ratio;
  logic [15:0] period_cnt;
  logic        ratio_ack4, div_pulse4, div_clk4, ratio_err4;
  logic [3:0]  cur_ratio4;
  logic [3:0]  period_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmd_divider u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ratio_in(ratio_in),
    .ratio_ack(ratio_ack), .div_pulse(div_pulse), .div_clk(div_clk),
    .cur_ratio(cur_ratio), .ratio_err(ratio_err), .period_cnt(period_cnt)
  );

  mmd_divider #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ratio_in(ratio_in),
    .ratio_ack(ratio_ack4), .div_pulse(div_pulse4), .div_clk(div_clk4),
    .cur_ratio(cur_ratio4), .ratio_err(ratio_err4), .period_cnt(period_cnt4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: position k inside a period of N ----------
  bit m_run = 0;
  int m_n = 0;
  int m_k = 0;
  int m_per = 0;
  bit m_err = 0;
  int cyc = 0;
  int p_q[$];
  int h_q[$];
  int hi_cnt = 0;

  always @(negedge clk) begin
    bit e_last, e_ack, e_clk;
    int r;
    cyc = cyc + 1;
    if (div_clk) hi_cnt = hi_cnt + 1;
    if (div_pulse) begin
      p_q.push_back(cyc);
      h_q.push_back(hi_cnt);
      hi_cnt = 0;
    end
    if (!rst_n) begin
      chk("rst_ack", 32'(ratio_ack), 0);
      chk("rst_pulse", 32'(div_pulse), 0);
      chk("rst_clk", 32'(div_clk), 0);
      chk("rst_cnt", 32'(period_cnt), 0);
      m_run = 0; m_n = 0; m_k = 0; m_per = 0; m_err = 0;
    end else begin
      e_last = m_run && (m_k == m_n - 1);
      e_ack  = enable && (!m_run || e_last);
      e_clk  = m_run && (2 * m_k < m_n);
      chk("ack", 32'(ratio_ack), 32'(e_ack));
      chk("pulse", 32'(div_pulse), 32'(e_last));
      chk("div_clk", 32'(div_clk), 32'(e_clk));
      chk("err", 32'(ratio_err), 32'(m_err));
      chk("period_cnt", 32'(period_cnt), 32'(m_per % 65536));
      chk("period_cnt4", 32'(period_cnt4), 32'(m_per % 16));
      if (m_run) chk("cur_ratio", 32'(cur_ratio), 32'(m_n));
      if (e_last) m_per = m_per + 1;
      if (e_ack) begin
        r = int'(ratio_in);
        if (r < 5) begin r = 5; m_err = 1; end
        else if (r > 12) begin r = 12; m_err = 1; end
        m_n = r; m_k = 0; m_run = 1;
      end else if (e_last) begin
        m_run = 0;
      end else if (m_run) begin
        m_k = m_k + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present r and hold it until the DUT acknowledges it.
  task automatic feed(input logic [3:0] r);
    int t = 0;
    ratio_in = r;
    @(negedge clk);
    while (!ratio_ack && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!ratio_ack) begin
      errors++;
      $display("FAIL ack_timeout actual=0 expected=1 at %0t", $time);
    end
    @(posedge clk); #1;
  endtask

  // Three back-to-back periods; checks pulse spacing and high time of the middle one.
  task automatic seq3(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                      input int e0, input int e1, input int e2, input int eh1);
    int c0, i0;
    feed(r0);
    c0 = cyc;
    i0 = p_q.size();
    feed(r1);
    feed(r2);
    feed(r2);
    chk("pulses_seen", 32'(p_q.size() - i0 >= 3), 1);
    if (p_q.size() - i0 >= 3) begin
      chk("len0", 32'(p_q[i0] - c0), 32'(e0));
      chk("len1", 32'(p_q[i0+1] - p_q[i0]), 32'(e1));
      chk("len2", 32'(p_q[i0+2] - p_q[i0+1]), 32'(e2));
      chk("high1", 32'(h_q[i0+1]), 32'(eh1));
    end
    $display("seq %0d,%0d,%0d: checks=%0d errors=%0d", r0, r1, r2, checks, errors);
  endtask

  initial begin
    int t, np;
    #2;
    chk("init_ack", 32'(ratio_ack), 0);
    chk("init_clk", 32'(div_clk), 0);
    chk("init_ratio", 32'(cur_ratio), 0);
    chk("init_err", 32'(ratio_err), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;

    seq3(4'd8, 4'd8, 4'd8, 8, 8, 8, 4);
    seq3(4'd5, 4'd5, 4'd5, 5, 5, 5, 3);
    seq3(4'd12, 4'd12, 4'd12, 12, 12, 12, 6);
    chk("err_still_0", 32'(ratio_err), 0);
    seq3(4'd5, 4'd12, 4'd7, 5, 12, 7, 6);
    seq3(4'd3, 4'd15, 4'd9, 5, 12, 9, 6);
    chk("err_set", 32'(ratio_err), 1);
    seq3(4'd8, 4'd8, 4'd8, 8, 8, 8, 4);
    chk("err_sticky", 32'(ratio_err), 1);

    // enable dropped at k=2 of an N=9 period
    feed(4'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0;
    t = 2;
    np = 0;
    while (np == 0 && t < 30) begin
      @(negedge clk);
      t++;
      if (div_pulse) begin
        np = 1;
        chk("drop_no_ack", 32'(ratio_ack), 0);
      end
    end
    chk("drop_len", 32'(t), 9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_clk", 32'(div_clk), 0);
    chk("idle_ack", 32'(ratio_ack), 0);
    @(posedge clk); #1;
    ratio_in = 4'd6;
    enable = 1'b1;
    @(negedge clk);
    chk("reen_ack", 32'(ratio_ack), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reen_ratio", 32'(cur_ratio), 6);
    chk("reen_clk", 32'(div_clk), 1);
    $display("enable drop/re-enable: checks=%0d errors=%0d", checks, errors);

    // asynchronous reset mid-period
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ar_clk", 32'(div_clk), 0);
    chk("ar_pulse", 32'(div_pulse), 0);
    chk("ar_ack", 32'(ratio_ack), 0);
    chk("ar_ratio", 32'(cur_ratio), 0);
    chk("ar_err", 32'(ratio_err), 0);
    chk("ar_cnt", 32'(period_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    ratio_in = 4'd5;
    rst_n = 1'b1;
    $display("async reset: checks=%0d errors=%0d", checks, errors);

    // 17 periods: 4-bit counter wraps to 1, 16-bit counter reads 17
    np = 0;
    t = 0;
    while (np < 17 && t < 200) begin
      @(negedge clk);
      t++;
      if (div_pulse) np++;
    end
    chk("wrap_pulses", 32'(np), 17);
    @(posedge clk); #1;
    chk("wrap_cnt4", 32'(period_cnt4), 1);
    chk("wrap_cnt16", 32'(period_cnt), 17);
    $display("wrap: checks=%0d errors=%0d", checks, errors);

    enable = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
